// File: rtl/ddr_burst_responder.sv
// ddr_burst_responder: arbitrates the data cache's load, store and jump-address
// requests onto one DDR burst read/write port and streams beats back to the cache.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   DATA_read_req               cache data-load request (level)
//   DATA_store_req              cache data-store request (level)
//   JMP_ADDR_read_req           cache jump-address request (level)
//   DATA_read_addr              load address, used for data and jump reads
//   DATA_write_addr             store address
//   DATA_to_ddr                 store beat from the cache
//   DATA_to_cache               registered read beat
//   JMP_ADDR_to_cache           zero-extended jump beat, held until the next one
//   rd_cnt_data                 read beat counter (DATA_CACHE_DEPTH+1 marks completion)
//   rd_burst_data_valid         DATA_to_cache / JMP_ADDR_to_cache valid
//   wr_burst_data_req           cache must present the next store beat
//   state_interface_module      current state encoding
//   mem_rd_burst_*              burst read port to the DDR burst controller
//   mem_wr_burst_*              burst write port to the DDR burst controller
module ddr_burst_responder #(
    parameter int DATA_WIDTH       = 16,
    parameter int DDR_ADDR_WIDTH   = 28,
    parameter int DATA_CACHE_DEPTH = 16,
    parameter int LEN_WIDTH        = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      DATA_read_req,
    input  logic                      DATA_store_req,
    input  logic                      JMP_ADDR_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
    input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
    output logic [DATA_WIDTH-1:0]     DATA_to_cache,
    output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
    output logic [LEN_WIDTH-1:0]      rd_cnt_data,
    output logic                      rd_burst_data_valid,
    output logic                      wr_burst_data_req,
    output logic [3:0]                state_interface_module,
    output logic                      mem_rd_burst_req,
    output logic                      mem_wr_burst_req,
    output logic [LEN_WIDTH-1:0]      mem_rd_burst_len,
    output logic [LEN_WIDTH-1:0]      mem_wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0] mem_rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0] mem_wr_burst_addr,
    input  logic                      mem_rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rd_burst_data,
    input  logic                      mem_rd_burst_finish,
    input  logic                      mem_wr_burst_finish,
    input  logic                      mem_wr_burst_data_req,
    output logic [DATA_WIDTH-1:0]     mem_wr_burst_data
);

    // Encoding is visible to the cache, which decodes the store state (9).
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RD_DATA    = 4'd1,
        S_RD_JMP     = 4'd2,
        S_WR_STORE   = 4'd9,
        S_WAIT_REL   = 4'd10
    } state_t;

    // Which cache request is being served, so WAIT_REL knows what to watch.
    typedef enum logic [1:0] {
        K_NONE,
        K_STORE,
        K_READ,
        K_JMP
    } kind_t;

    localparam logic [LEN_WIDTH-1:0] LEN_DATA = LEN_WIDTH'(DATA_CACHE_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_JMP  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] CNT_DONE = LEN_WIDTH'(DATA_CACHE_DEPTH + 1);
    localparam logic [LEN_WIDTH-1:0] CNT_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] CNT_MAX  = '1;

    state_t r_state;
    state_t w_state_nxt;
    kind_t  r_kind;
    kind_t  w_kind_nxt;

    logic                      r_rd_fin;
    logic                      r_rd_req;
    logic                      r_wr_req;
    logic [LEN_WIDTH-1:0]      r_rd_len;
    logic [LEN_WIDTH-1:0]      r_wr_len;
    logic [DDR_ADDR_WIDTH-1:0] r_rd_addr;
    logic [DDR_ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [DDR_ADDR_WIDTH-1:0] r_jmp;
    logic [LEN_WIDTH-1:0]      r_cnt;
    logic                      r_valid;

    logic                      w_rd_beat;
    logic                      w_data_done;
    logic                      w_released;
    logic [LEN_WIDTH-1:0]      w_cnt_inc;
    logic [DDR_ADDR_WIDTH-1:0] w_jmp_beat;

    assign w_rd_beat  = mem_rd_burst_data_valid &&
                        (r_state == S_RD_DATA || r_state == S_RD_JMP);
    // A data burst completes on the first beat-free cycle once finish was seen,
    // so the last beat is always delivered before the completion marker.
    assign w_data_done = (r_state == S_RD_DATA) && !mem_rd_burst_data_valid &&
                         (r_rd_fin || mem_rd_burst_finish);
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
    assign w_jmp_beat = DDR_ADDR_WIDTH'(mem_rd_burst_data);

    always_comb begin
        w_released = 1'b1;
        case (r_kind)
            K_STORE: w_released = !DATA_store_req;
            K_READ:  w_released = !DATA_read_req;
            K_JMP:   w_released = !JMP_ADDR_read_req;
            default: w_released = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_kind  <= K_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        case (r_state)
            S_IDLE: begin
                // Store first so dirty lines reach DDR before any reload.
                if (DATA_store_req) begin
                    w_state_nxt = S_WR_STORE;
                    w_kind_nxt  = K_STORE;
                end else if (DATA_read_req) begin
                    w_state_nxt = S_RD_DATA;
                    w_kind_nxt  = K_READ;
                end else if (JMP_ADDR_read_req) begin
                    w_state_nxt = S_RD_JMP;
                    w_kind_nxt  = K_JMP;
                end
            end
            S_RD_DATA: begin
                if (w_data_done) w_state_nxt = S_WAIT_REL;
            end
            S_RD_JMP: begin
                if (mem_rd_burst_finish) w_state_nxt = S_WAIT_REL;
            end
            S_WR_STORE: begin
                if (mem_wr_burst_finish) w_state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (w_released) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_fin  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
            r_rd_len  <= '0;
            r_wr_len  <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_data    <= '0;
            r_jmp     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt != S_IDLE) begin
                        r_cnt    <= '0;
                        r_rd_fin <= 1'b0;
                    end
                    if (w_state_nxt == S_WR_STORE) begin
                        r_wr_addr <= DATA_write_addr;
                        r_wr_len  <= LEN_DATA;
                    end else if (w_state_nxt == S_RD_DATA) begin
                        r_rd_addr <= DATA_read_addr;
                        r_rd_len  <= LEN_DATA;
                    end else if (w_state_nxt == S_RD_JMP) begin
                        r_rd_addr <= DATA_read_addr;
                        r_rd_len  <= LEN_JMP;
                    end
                end
                S_RD_DATA: begin
                    // Request rises one cycle after acceptance and never returns
                    // once the controller has signalled finish.
                    r_rd_req <= !(r_rd_fin || mem_rd_burst_finish);
                    if (mem_rd_burst_finish) r_rd_fin <= 1'b1;
                    if (w_rd_beat) begin
                        r_data  <= mem_rd_burst_data;
                        r_valid <= 1'b1;
                        r_cnt   <= w_cnt_inc;
                    end else if (w_data_done) begin
                        r_cnt <= CNT_DONE;
                    end
                end
                S_RD_JMP: begin
                    r_rd_req <= !mem_rd_burst_finish;
                    if (w_rd_beat) begin
                        r_jmp   <= w_jmp_beat;
                        r_valid <= 1'b1;
                        r_cnt   <= CNT_ONE;
                    end
                end
                S_WR_STORE: begin
                    r_wr_req <= !mem_wr_burst_finish;
                end
                default: begin
                end
            endcase
        end
    end

    assign DATA_to_cache          = r_data;
    assign JMP_ADDR_to_cache      = r_jmp;
    assign rd_cnt_data            = r_cnt;
    assign rd_burst_data_valid    = r_valid;
    assign state_interface_module = r_state;
    assign mem_rd_burst_req       = r_rd_req;
    assign mem_wr_burst_req       = r_wr_req;
    assign mem_rd_burst_len       = r_rd_len;
    assign mem_wr_burst_len       = r_wr_len;
    assign mem_rd_burst_addr      = r_rd_addr;
    assign mem_wr_burst_addr      = r_wr_addr;

    // Store beats bypass registers so the controller's beat request reaches
    // the cache and the beat returns within the same cycle.
    assign wr_burst_data_req = (r_state == S_WR_STORE) && mem_wr_burst_data_req;
    assign mem_wr_burst_data = (r_state == S_WR_STORE) ? DATA_to_ddr : '0;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Self-checking bench for ddr_burst_responder: arbitration table, directed
// burst sequences and randomized bursts against a beat-queue reference.
module tb_ddr_burst_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        DATA_read_req;
    logic        DATA_store_req;
    logic        JMP_ADDR_read_req;
    logic [27:0] DATA_read_addr;
    logic [27:0] DATA_write_addr;
    logic [15:0] DATA_to_ddr;
    logic [15:0] DATA_to_cache;
    logic [27:0] JMP_ADDR_to_cache;
    logic [9:0]  rd_cnt_data;
    logic        rd_burst_data_valid;
    logic        wr_burst_data_req;
    logic [3:0]  state_interface_module;
    logic        mem_rd_burst_req;
    logic        mem_wr_burst_req;
    logic [9:0]  mem_rd_burst_len;
    logic [9:0]  mem_wr_burst_len;
    logic [27:0] mem_rd_burst_addr;
    logic [27:0] mem_wr_burst_addr;
    logic        mem_rd_burst_data_valid;
    logic [15:0] mem_rd_burst_data;
    logic        mem_rd_burst_finish;
    logic        mem_wr_burst_finish;
    logic        mem_wr_burst_data_req;
    logic [15:0] mem_wr_burst_data;

    int checks = 0;
    int errors = 0;

    ddr_burst_responder dut (
        .clk                    (clk),
        .rst                    (rst),
        .DATA_read_req          (DATA_read_req),
        .DATA_store_req         (DATA_store_req),
        .JMP_ADDR_read_req      (JMP_ADDR_read_req),
        .DATA_read_addr         (DATA_read_addr),
        .DATA_write_addr        (DATA_write_addr),
        .DATA_to_ddr            (DATA_to_ddr),
        .DATA_to_cache          (DATA_to_cache),
        .JMP_ADDR_to_cache      (JMP_ADDR_to_cache),
        .rd_cnt_data            (rd_cnt_data),
        .rd_burst_data_valid    (rd_burst_data_valid),
        .wr_burst_data_req      (wr_burst_data_req),
        .state_interface_module (state_interface_module),
        .mem_rd_burst_req       (mem_rd_burst_req),
        .mem_wr_burst_req       (mem_wr_burst_req),
        .mem_rd_burst_len       (mem_rd_burst_len),
        .mem_wr_burst_len       (mem_wr_burst_len),
        .mem_rd_burst_addr      (mem_rd_burst_addr),
        .mem_wr_burst_addr      (mem_wr_burst_addr),
        .mem_rd_burst_data_valid(mem_rd_burst_data_valid),
        .mem_rd_burst_data      (mem_rd_burst_data),
        .mem_rd_burst_finish    (mem_rd_burst_finish),
        .mem_wr_burst_finish    (mem_wr_burst_finish),
        .mem_wr_burst_data_req  (mem_wr_burst_data_req),
        .mem_wr_burst_data      (mem_wr_burst_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs of that edge are sampled 2 time units later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        DATA_read_req           = 0;
        DATA_store_req          = 0;
        JMP_ADDR_read_req       = 0;
        DATA_read_addr          = 0;
        DATA_write_addr         = 0;
        DATA_to_ddr             = 0;
        mem_rd_burst_data_valid = 0;
        mem_rd_burst_data       = 0;
        mem_rd_burst_finish     = 0;
        mem_wr_burst_finish     = 0;
        mem_wr_burst_data_req   = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    // Reference: the cache must see beat k (1-based) with count k one cycle
    // after the controller sends it, then the completion marker, then wait
    // for release of the request before anything new starts.
    task automatic run_read(input bit jmp, input logic [27:0] addr,
                            input logic [15:0] base, input int gap_max,
                            input bit fin_late, input int hold);
        int n;
        logic [15:0] q[$];
        n = jmp ? 1 : DEPTH;
        for (int i = 0; i < n; i++) q.push_back(base + 16'(i));
        DATA_read_addr = addr;
        if (jmp) JMP_ADDR_read_req = 1;
        else DATA_read_req = 1;
        cyc();
        chk("rd_state", state_interface_module, jmp ? 4'd2 : 4'd1);
        chk("rd_req_early", mem_rd_burst_req, 0);
        chk("rd_cnt_clr", rd_cnt_data, 0);
        cyc();
        chk("rd_req", mem_rd_burst_req, 1);
        chk("rd_len", mem_rd_burst_len, jmp ? 1 : DEPTH);
        chk("rd_addr", mem_rd_burst_addr, addr);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                cyc();
                chk("rd_gap_valid", rd_burst_data_valid, 0);
            end
            mem_rd_burst_data_valid = 1;
            mem_rd_burst_data       = q[i];
            mem_rd_burst_finish     = (i == n - 1) && !fin_late;
            cyc();
            mem_rd_burst_data_valid = 0;
            mem_rd_burst_finish     = 0;
            mem_rd_burst_data       = 16'($urandom);
            chk("rd_valid", rd_burst_data_valid, 1);
            chk("rd_cnt", rd_cnt_data, i + 1);
            if (jmp) chk("jmp_val", JMP_ADDR_to_cache, {12'h0, q[i]});
            else chk("rd_data", DATA_to_cache, q[i]);
        end
        if (fin_late) mem_rd_burst_finish = 1;
        cyc();
        mem_rd_burst_finish = 0;
        chk("rd_end_valid", rd_burst_data_valid, 0);
        chk("rd_end_state", state_interface_module, 10);
        chk("rd_end_req", mem_rd_burst_req, 0);
        chk("rd_marker", rd_cnt_data, jmp ? 1 : DEPTH + 1);
        if (jmp) chk("jmp_hold", JMP_ADDR_to_cache, {12'h0, q[0]});
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("hold_state", state_interface_module, 10);
            chk("hold_no_req", mem_rd_burst_req, 0);
            chk("hold_cnt", rd_cnt_data, jmp ? 1 : DEPTH + 1);
        end
        DATA_read_req     = 0;
        JMP_ADDR_read_req = 0;
        cyc();
        chk("rd_idle", state_interface_module, 0);
        chk("rd_idle_req", mem_rd_burst_req, 0);
    endtask

    task automatic run_store(input logic [27:0] addr, input bit also_read,
                             input int gap_max, input int hold);
        logic [15:0] d;
        DATA_write_addr = addr;
        DATA_store_req  = 1;
        if (also_read) DATA_read_req = 1;
        cyc();
        chk("wr_state", state_interface_module, 9);
        chk("wr_req_early", mem_wr_burst_req, 0);
        cyc();
        chk("wr_req", mem_wr_burst_req, 1);
        chk("wr_len", mem_wr_burst_len, DEPTH);
        chk("wr_addr", mem_wr_burst_addr, addr);
        if (also_read) chk("wr_no_rd_req", mem_rd_burst_req, 0);
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                mem_wr_burst_data_req = 0;
                #1;
                chk("wr_gap_req", wr_burst_data_req, 0);
                cyc();
            end
            d                     = 16'($urandom);
            DATA_to_ddr           = d;
            mem_wr_burst_data_req = 1;
            mem_wr_burst_finish   = (i == DEPTH - 1);
            #1;
            chk("wr_beat_req", wr_burst_data_req, 1);
            chk("wr_beat_data", mem_wr_burst_data, d);
            cyc();
            mem_wr_burst_data_req = 0;
            mem_wr_burst_finish   = 0;
        end
        chk("wr_end_state", state_interface_module, 10);
        chk("wr_end_req", mem_wr_burst_req, 0);
        mem_wr_burst_data_req = 1;
        #1;
        chk("wr_gated", wr_burst_data_req, 0);
        mem_wr_burst_data_req = 0;
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("wr_hold_state", state_interface_module, 10);
            chk("wr_hold_req", mem_wr_burst_req, 0);
            chk("wr_hold_rd", mem_rd_burst_req, 0);
        end
        DATA_store_req = 0;
        cyc();
        chk("wr_idle", state_interface_module, 0);
    endtask

    typedef struct {
        logic       st;
        logic       rd;
        logic       jp;
        logic [3:0] state;
        logic       rreq;
        logic       wreq;
        logic [9:0] len;
        logic [27:0] addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 0, 0, 4'd0, 0, 0, 10'd0, 28'h0};
        vecs[1] = '{1, 0, 0, 4'd9, 0, 1, 10'd16, 28'h400};
        vecs[2] = '{0, 1, 0, 4'd1, 1, 0, 10'd16, 28'h80};
        vecs[3] = '{0, 0, 1, 4'd2, 1, 0, 10'd1, 28'h80};
        vecs[4] = '{1, 1, 0, 4'd9, 0, 1, 10'd16, 28'h400};
        vecs[5] = '{1, 0, 1, 4'd9, 0, 1, 10'd16, 28'h400};
        vecs[6] = '{0, 1, 1, 4'd1, 1, 0, 10'd16, 28'h80};
        vecs[7] = '{1, 1, 1, 4'd9, 0, 1, 10'd16, 28'h400};

        do_reset();
        chk("rst_state", state_interface_module, 0);
        chk("rst_cnt", rd_cnt_data, 0);
        chk("rst_valid", rd_burst_data_valid, 0);
        chk("rst_data", DATA_to_cache, 0);
        chk("rst_jmp", JMP_ADDR_to_cache, 0);
        chk("rst_rdreq", mem_rd_burst_req, 0);
        chk("rst_wrreq", mem_wr_burst_req, 0);
        chk("rst_rdlen", mem_rd_burst_len, 0);
        chk("rst_wrdata", mem_wr_burst_data, 0);

        // Beats outside a read state are ignored.
        mem_rd_burst_data_valid = 1;
        mem_rd_burst_data       = 16'hBEEF;
        cyc();
        mem_rd_burst_data_valid = 0;
        chk("idle_beat_valid", rd_burst_data_valid, 0);
        chk("idle_beat_data", DATA_to_cache, 0);
        chk("idle_beat_cnt", rd_cnt_data, 0);

        // Arbitration table.
        foreach (vecs[k]) begin
            do_reset();
            DATA_read_addr    = 28'h80;
            DATA_write_addr   = 28'h400;
            DATA_store_req    = vecs[k].st;
            DATA_read_req     = vecs[k].rd;
            JMP_ADDR_read_req = vecs[k].jp;
            cyc();
            chk("arb_state", state_interface_module, vecs[k].state);
            cyc();
            chk("arb_rreq", mem_rd_burst_req, vecs[k].rreq);
            chk("arb_wreq", mem_wr_burst_req, vecs[k].wreq);
            if (vecs[k].wreq) begin
                chk("arb_len", mem_wr_burst_len, vecs[k].len);
                chk("arb_addr", mem_wr_burst_addr, vecs[k].addr);
            end else begin
                chk("arb_len", mem_rd_burst_len, vecs[k].len);
                chk("arb_addr", mem_rd_burst_addr, vecs[k].addr);
            end
        end

        // Directed sequences.
        do_reset();
        run_read(0, 28'h80, 16'h1000, 0, 0, 1);
        run_read(1, 28'h90, 16'h1234, 0, 0, 2);
        run_store(28'h400, 0, 0, 1);
        run_store(28'h500, 1, 1, 2);
        run_read(0, 28'h80, 16'h5000, 1, 1, 0);
        run_read(0, 28'hC0, 16'h7000, 0, 1, 6);

        // Reset asserted with read beat 5.
        DATA_read_addr = 28'h80;
        DATA_read_req  = 1;
        cyc();
        cyc();
        for (int i = 1; i <= 5; i++) begin
            mem_rd_burst_data_valid = 1;
            mem_rd_burst_data       = 16'h3000 + 16'(i);
            if (i == 5) begin
                rst           = 1;
                DATA_read_req = 0;
            end
            cyc();
        end
        rst                     = 0;
        mem_rd_burst_data_valid = 0;
        chk("mid_rst_cnt", rd_cnt_data, 0);
        chk("mid_rst_valid", rd_burst_data_valid, 0);
        chk("mid_rst_data", DATA_to_cache, 0);
        chk("mid_rst_req", mem_rd_burst_req, 0);
        chk("mid_rst_state", state_interface_module, 0);
        chk("mid_rst_addr", mem_rd_burst_addr, 0);
        run_read(0, 28'h80, 16'h2000, 0, 0, 0);

        // Counter saturation with an overlong burst.
        DATA_read_addr = 28'h100;
        DATA_read_req  = 1;
        cyc();
        cyc();
        for (int k = 1; k <= 1030; k++) begin
            mem_rd_burst_data_valid = 1;
            mem_rd_burst_data       = 16'(k);
            cyc();
            if (k == 1022 || k == 1023 || k == 1030)
                chk("sat_cnt", rd_cnt_data, (k > 1023) ? 1023 : k);
        end
        mem_rd_burst_data_valid = 0;
        mem_rd_burst_finish     = 1;
        cyc();
        mem_rd_burst_finish = 0;
        chk("sat_marker", rd_cnt_data, DEPTH + 1);
        chk("sat_state", state_interface_module, 10);
        DATA_read_req = 0;
        cyc();
        chk("sat_idle", state_interface_module, 0);

        // Randomized bursts.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: run_read(0, 28'($urandom), 16'($urandom),
                            $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3));
                1: run_read(1, 28'($urandom), 16'($urandom),
                            $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3));
                2: run_store(28'($urandom), 0, $urandom_range(0, 2), $urandom_range(0, 3));
                default: begin
                    run_store(28'($urandom), 1, $urandom_range(0, 2), $urandom_range(0, 3));
                    run_read(0, 28'($urandom), 16'($urandom),
                             $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_burst_responder.md
# ddr_burst_responder

Memory-side responder for the data cache's DDR request interface. Accepts the cache's level-sensitive data-load, data-store and jump-address-load requests and arbitrates them onto a single burst read/write port of the DDR burst controller. Streams read beats back to the cache with a beat counter and paces store beats with a per-beat data request. Sits between the data cache and the DDR burst controller.

## Interface

Parameters:
- DATA_WIDTH, 16, beat width
- DDR_ADDR_WIDTH, 28, DDR byte address width
- DATA_CACHE_DEPTH, 16, beats per data burst (load and store)
- LEN_WIDTH, 10, burst length / beat counter width

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge
- rst  in  1  reset; **synchronous, active-high**
- DATA_read_req  in  1  cache data-load request (level, held until completion seen)
- DATA_store_req  in  1  cache data-store request (level)
- JMP_ADDR_read_req  in  1  cache jump-address request (level)
- DATA_read_addr  in  DDR_ADDR_WIDTH  load address (used for both data and jump reads)
- DATA_write_addr  in  DDR_ADDR_WIDTH  store address
- DATA_to_ddr  in  DATA_WIDTH  store beat from cache
- DATA_to_cache  out  DATA_WIDTH  registered read beat
- JMP_ADDR_to_cache  out  DDR_ADDR_WIDTH  jump address, zero-extended beat, held
- rd_cnt_data  out  LEN_WIDTH  read beat counter
- rd_burst_data_valid  out  1  DATA_to_cache valid
- wr_burst_data_req  out  1  cache must present next store beat
- state_interface_module  out  4  current state encoding
- mem_rd_burst_req / mem_wr_burst_req  out  1  burst requests, held until finish
- mem_rd_burst_len / mem_wr_burst_len  out  LEN_WIDTH  burst lengths
- mem_rd_burst_addr / mem_wr_burst_addr  out  DDR_ADDR_WIDTH  burst addresses
- mem_rd_burst_data_valid  in  1  read beat valid
- mem_rd_burst_data  in  DATA_WIDTH  read beat
- mem_rd_burst_finish / mem_wr_burst_finish  in  1  one-cycle completion pulses
- mem_wr_burst_data_req  in  1  controller consumes a write beat this cycle
- mem_wr_burst_data  out  DATA_WIDTH  write beat

## Operation

- States (encoding fixed, the cache decodes 9): IDLE=0, MEM_READ_DATA=1, MEM_READ_JMP=2, MEM_WRITE_DATA_STORE=9, WAIT_RELEASE=10.
- IDLE arbitration, fixed priority: DATA_store_req > DATA_read_req > JMP_ADDR_read_req. Store wins so dirty lines reach DDR before any reload.
- On acceptance: latch address into mem_*_burst_addr; len = DATA_CACHE_DEPTH for data, 1 for jump; clear rd_cnt_data to 0; assert mem_*_burst_req next cycle.
- MEM_READ_DATA, per mem_rd_burst_data_valid beat n (1-based):
  - next cycle DATA_to_cache = beat, rd_burst_data_valid = 1, rd_cnt_data = n.
- On mem_rd_burst_finish: drop req. The cycle after the last beat is delivered, rd_cnt_data = DATA_CACHE_DEPTH+1 (completion marker) and valid = 0. Then go to WAIT_RELEASE.
- MEM_READ_JMP: on the single beat, JMP_ADDR_to_cache = zero-extended beat, valid = 1 and rd_cnt_data = 1 for one cycle. JMP_ADDR_to_cache holds until the next jump beat. On finish, go to WAIT_RELEASE.
- MEM_WRITE_DATA_STORE:
  - wr_burst_data_req = mem_wr_burst_data_req (combinational pass-through, gated by state).
  - mem_wr_burst_data = DATA_to_ddr (pass-through).
  - On mem_wr_burst_finish: drop req, go to WAIT_RELEASE.
- WAIT_RELEASE: stay until the request that was served is low, then go to IDLE. This prevents re-issuing a burst while the cache is leaving its state. rd_cnt_data holds its value here.
- Beats arriving outside a read state are ignored.

## Timing

- Reset values: all outputs 0, state IDLE, rd_cnt_data 0, JMP_ADDR_to_cache 0.
- rst high mid-burst: the next edge forces reset values and drops mem requests. The partially transferred burst is abandoned.
- Request to mem_*_burst_req high: 2 cycles (IDLE sample, then registered req).
- Read beat to cache-visible beat: 1 cycle.
- Write beat: 0-cycle combinational path from mem_wr_burst_data_req to wr_burst_data_req.
- Simultaneous store and read requests in IDLE: store is served. The read is served after the store completes and the store request has been released.
- Finish pulse arriving on the same cycle as the last valid beat: the beat is delivered, the marker is produced on the following cycle.
- rd_cnt_data saturates at 2^LEN_WIDTH-1. It never wraps.

## Test plan

- Data load, DATA_read_addr=0x80, beats 0x1000..0x100F:
  - mem len 16, addr 0x80.
  - Cache sees rd_cnt_data 1..16 with matching data one cycle after each beat, then 17.
  - Returns to IDLE after the request drops.
- Jump load, beat 0x1234: JMP_ADDR_to_cache=0x0001234, rd_cnt_data=1 with valid for exactly 1 cycle; value holds afterwards.
- Store, DATA_write_addr=0x400: state_interface_module=9; 16 mem_wr_burst_data_req pulses mirrored on wr_burst_data_req; mem_wr_burst_data equals DATA_to_ddr each cycle.
- DATA_store_req and DATA_read_req raised on the same cycle: write burst first, then read burst only after DATA_store_req falls.
- rst asserted at read beat 5: next cycle all outputs 0 and mem_rd_burst_req 0; a fresh load afterwards counts from 1.
- Request held high after finish: no second mem request is issued until the request falls.
